vid_phy_controller_v2_2_20_rx_align_ctrl: RTL and testbench



---
 rtl/vid_phy_controller_v2_2_20_align_pkg.sv | 32 +++
 rtl/vid_phy_controller_v2_2_20_align_tok_det.sv | 23 ++
 rtl/vid_phy_controller_v2_2_20_rx_align_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_vid_phy_controller_v2_2_20_rx_align_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_phy_controller_v2_2_20_align_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vid_phy_controller_v2_2_20_align_pkg
// Purpose  : Shared types and constants for the HDMI RX lane symbol aligner.
// Revision : 1.0 - initial release
// ============================================================================
package vid_phy_controller_v2_2_20_align_pkg;

    localparam int SYM_W   = 10;
    localparam int LNK_W   = 40;
    localparam int NUM_OFS = 10;
    localparam int NUM_SYM = LNK_W / SYM_W;
    // Only the low bits of the 80-bit {current, previous} window are ever addressed.
    localparam int WIN_W   = NUM_OFS - 1 + LNK_W;

    localparam logic [SYM_W-1:0] CTL0 = 10'h354;
    localparam logic [SYM_W-1:0] CTL1 = 10'h0AB;
    localparam logic [SYM_W-1:0] CTL2 = 10'h154;
    localparam logic [SYM_W-1:0] CTL3 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    function automatic logic is_ctl(input logic [SYM_W-1:0] sym);
        return (sym == CTL0) || (sym == CTL1) || (sym == CTL2) || (sym == CTL3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vid_phy_controller_v2_2_20_align_tok_det.sv
`default_nettype none
// ============================================================================
// Module   : vid_phy_controller_v2_2_20_align_tok_det
// Purpose  : Combinational TMDS control-token detector, one flag per bit offset.
// Revision : 1.0 - initial release
// ============================================================================
module vid_phy_controller_v2_2_20_align_tok_det
    import vid_phy_controller_v2_2_20_align_pkg::*;
(
    input  logic [WIN_W-1:0]   i_win,
    output logic [NUM_OFS-1:0] o_hit
);

    for (genvar k = 0; k < NUM_OFS; k++) begin : g_ofs
        logic [NUM_SYM-1:0] w_sym_hit;
        for (genvar i = 0; i < NUM_SYM; i++) begin : g_sym
            assign w_sym_hit[i] = is_ctl(i_win[k + SYM_W*i +: SYM_W]);
        end
        assign o_hit[k] = |w_sym_hit;
    end

endmodule
`default_nettype wire

// File: rtl/vid_phy_controller_v2_2_20_rx_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vid_phy_controller_v2_2_20_rx_align_ctrl
// Purpose  : HDMI RX lane symbol aligner: search/verify/lock FSM + barrel shift.
//            VID_PHY_CONTROLLER_V2_2_20_ALIGN_STAT_EN adds a relock counter.
// Revision : 1.0 - initial release
// ============================================================================
module vid_phy_controller_v2_2_20_rx_align_ctrl
    import vid_phy_controller_v2_2_20_align_pkg::*;
#(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int VERIFY_TMO = 4096
) (
    input  logic        CLK_IN,
    input  logic        RSTN_IN,
    input  logic        EN_IN,
    input  logic [39:0] DAT_IN,
`ifdef VID_PHY_CONTROLLER_V2_2_20_ALIGN_STAT_EN
    input  logic [0:0]  STAT_CLR_IN,
    output logic [15:0] RELOCK_CNT_OUT,
`endif
    output logic [39:0] DAT_OUT,
    output logic        LOCK_OUT,
    output logic [3:0]  OFFSET_OUT
);

    localparam int c_hit_w = (LOCK_CNT   > 2) ? $clog2(LOCK_CNT)   : 1;
    localparam int c_err_w = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT) : 1;
    localparam int c_tmo_w = $clog2(VERIFY_TMO);
    localparam logic [c_hit_w-1:0] c_hit_last = c_hit_w'(LOCK_CNT - 1);
    localparam logic [c_err_w-1:0] c_err_last = c_err_w'(UNLOCK_CNT - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(VERIFY_TMO - 1);

    align_state_t       r_state,   w_state_nxt;
    logic [3:0]         r_off,     w_off_nxt;
    logic [c_hit_w-1:0] r_hit_cnt, w_hit_cnt_nxt;
    logic [c_err_w-1:0] r_err_cnt, w_err_cnt_nxt;
    logic [c_tmo_w-1:0] r_tmo,     w_tmo_nxt;
    logic               r_lock,    w_lock_nxt;
    logic [LNK_W-1:0]   r_prev;
    logic [LNK_W-1:0]   r_dat;

    logic [WIN_W-1:0]   w_win;
    logic [NUM_OFS-1:0] w_hit;
    logic               w_any;
    logic               w_hit_off;
    logic [3:0]         w_first;
    logic [LNK_W-1:0]   w_shift [NUM_OFS];
    logic [LNK_W-1:0]   w_dat_nxt;

    assign w_win = {DAT_IN[WIN_W-LNK_W-1:0], r_prev};

    vid_phy_controller_v2_2_20_align_tok_det u_tok_det (
        .i_win (w_win),
        .o_hit (w_hit)
    );

    assign w_any     = |w_hit;
    assign w_hit_off = w_hit[r_off];

    always_comb begin
        w_first = 4'd0;
        for (int k = NUM_OFS - 1; k >= 0; k--) begin
            if (w_hit[k]) w_first = 4'(k);
        end
    end

    for (genvar k = 0; k < NUM_OFS; k++) begin : g_shf
        assign w_shift[k] = w_win[k +: LNK_W];
    end

    always_comb begin
        w_dat_nxt = w_shift[0];
        for (int k = 1; k < NUM_OFS; k++) begin
            if (r_off == 4'(k)) w_dat_nxt = w_shift[k];
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_off_nxt     = r_off;
        w_hit_cnt_nxt = r_hit_cnt;
        w_err_cnt_nxt = r_err_cnt;
        w_tmo_nxt     = r_tmo;
        w_lock_nxt    = r_lock;
        if (!EN_IN) begin
            w_state_nxt   = SEARCH;
            w_lock_nxt    = 1'b0;
            w_hit_cnt_nxt = '0;
            w_err_cnt_nxt = '0;
            w_tmo_nxt     = '0;
        end else begin
            case (r_state)
                SEARCH: begin
                    w_lock_nxt = 1'b0;
                    if (w_any) begin
                        w_state_nxt   = VERIFY;
                        w_off_nxt     = w_first;
                        w_hit_cnt_nxt = c_hit_w'(1);
                        w_err_cnt_nxt = '0;
                        w_tmo_nxt     = '0;
                    end
                end
                VERIFY: begin
                    // A hit at the candidate offset wins over hits elsewhere.
                    if (w_hit_off) begin
                        w_tmo_nxt = '0;
                        if (r_hit_cnt == c_hit_last) begin
                            w_state_nxt   = LOCKED;
                            w_lock_nxt    = 1'b1;
                            w_hit_cnt_nxt = '0;
                            w_err_cnt_nxt = '0;
                        end else begin
                            w_hit_cnt_nxt = r_hit_cnt + c_hit_w'(1);
                        end
                    end else if (w_any || (r_tmo == c_tmo_last)) begin
                        w_state_nxt   = SEARCH;
                        w_hit_cnt_nxt = '0;
                        w_tmo_nxt     = '0;
                    end else begin
                        w_tmo_nxt = r_tmo + c_tmo_w'(1);
                    end
                end
                LOCKED: begin
                    // No token at all is active video and leaves the error count alone.
                    if (w_hit_off) begin
                        w_err_cnt_nxt = '0;
                    end else if (w_any) begin
                        if (r_err_cnt == c_err_last) begin
                            w_state_nxt   = SEARCH;
                            w_lock_nxt    = 1'b0;
                            w_err_cnt_nxt = '0;
                        end else begin
                            w_err_cnt_nxt = r_err_cnt + c_err_w'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = SEARCH;
                    w_lock_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_IN or negedge RSTN_IN) begin
        if (!RSTN_IN) begin
            r_state   <= SEARCH;
            r_off     <= 4'd0;
            r_hit_cnt <= '0;
            r_err_cnt <= '0;
            r_tmo     <= '0;
            r_lock    <= 1'b0;
            r_prev    <= '0;
            r_dat     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_off     <= w_off_nxt;
            r_hit_cnt <= w_hit_cnt_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_tmo     <= w_tmo_nxt;
            r_lock    <= w_lock_nxt;
            r_prev    <= DAT_IN;
            r_dat     <= w_dat_nxt;
        end
    end

`ifdef VID_PHY_CONTROLLER_V2_2_20_ALIGN_STAT_EN
    logic [15:0] r_relock_cnt;
    logic        w_unlock;

    assign w_unlock = (r_state == LOCKED) && (w_state_nxt == SEARCH);

    always_ff @(posedge CLK_IN or negedge RSTN_IN) begin
        if (!RSTN_IN) begin
            r_relock_cnt <= 16'd0;
        end else if (STAT_CLR_IN[0]) begin
            r_relock_cnt <= 16'd0;
        end else if (w_unlock && (r_relock_cnt != 16'hFFFF)) begin
            r_relock_cnt <= r_relock_cnt + 16'd1;
        end
    end

    assign RELOCK_CNT_OUT = r_relock_cnt;
`endif

    assign DAT_OUT    = r_dat;
    assign LOCK_OUT   = r_lock;
    assign OFFSET_OUT = r_off;

endmodule
`default_nettype wire

// File: tb/tb_vid_phy_controller_v2_2_20_rx_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vid_phy_controller_v2_2_20_rx_align_ctrl
// Purpose  : Directed, table-driven bench for the RX lane symbol aligner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vid_phy_controller_v2_2_20_rx_align_ctrl;

    typedef struct {
        logic        en;
        logic [39:0] dat;
        logic        exp_lock;
        logic [3:0]  exp_off;
        logic        chk_dat;
        logic [39:0] exp_dat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [39:0] din;
    logic [39:0] dout;
    logic        lock;
    logic [3:0]  off;
`ifdef VID_PHY_CONTROLLER_V2_2_20_ALIGN_STAT_EN
    logic [0:0]  stat_clr;
    logic [15:0] relock;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vid_phy_controller_v2_2_20_rx_align_ctrl #(
        .LOCK_CNT   (8),
        .UNLOCK_CNT (4),
        .VERIFY_TMO (4096)
    ) dut (
        .CLK_IN         (clk),
        .RSTN_IN        (rstn),
        .EN_IN          (en),
        .DAT_IN         (din),
`ifdef VID_PHY_CONTROLLER_V2_2_20_ALIGN_STAT_EN
        .STAT_CLR_IN    (stat_clr),
        .RELOCK_CNT_OUT (relock),
`endif
        .DAT_OUT        (dout),
        .LOCK_OUT       (lock),
        .OFFSET_OUT     (off)
    );

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic [39:0] d);
        @(negedge clk);
        en  = e;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input logic e, input logic [39:0] d, input logic xl,
                            input logic [3:0] xo, input string nm);
        step(e, d);
        chk({nm, " lock"}, 40'(lock), 40'(xl));
        chk({nm, " off"},  40'(off),  40'(xo));
    endtask

    // Control token 10'h354 sitting k bits up in an otherwise zero word.
    function automatic logic [39:0] tok(input int k);
        logic [39:0] t;
        t = 40'h354;
        return t << k;
    endfunction

    // Every bit doubled: no run of length one, so no "10101" and no token anywhere.
    function automatic logic [39:0] dbl(input logic [19:0] r);
        logic [39:0] x;
        for (int i = 0; i < 20; i++) begin
            x[2*i]   = r[i];
            x[2*i+1] = r[i];
        end
        return x;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        en   = 1'b0;
        din  = '0;
`ifdef VID_PHY_CONTROLLER_V2_2_20_ALIGN_STAT_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic lock_at(input int k);
        repeat (9) step(1'b1, tok(k));
        chk("lock_at lock", 40'(lock), 40'd1);
        chk("lock_at off",  40'(off),  40'(k));
        chk("lock_at dat",  dout,      40'h354);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        vt [12];
        logic [9:0]  pat [6];
        logic [39:0] orig;
        logic [39:0] prev_orig;
        logic [39:0] last;
        logic [39:0] w;
        logic [39:0] seq_c2 [9];

        pat = '{10'h000, 10'h3E0, 10'h01F, 10'h3FF, 10'h0F0, 10'h30C};
        prev_orig = '0;
        for (int n = 0; n < 12; n++) begin
            orig = {10'h000, pat[n % 6], 10'h000, 10'h354};
            vt[n].en       = 1'b1;
            vt[n].dat      = orig << 3;
            vt[n].exp_lock = (n >= 8);
            vt[n].exp_off  = (n >= 1) ? 4'd3 : 4'd0;
            vt[n].chk_dat  = (n >= 2);
            vt[n].exp_dat  = prev_orig;
            prev_orig      = orig;
        end

        rstn = 1'b1;
        en   = 1'b0;
        din  = '0;
`ifdef VID_PHY_CONTROLLER_V2_2_20_ALIGN_STAT_EN
        stat_clr = 1'b0;
`endif

        // Reset values, then token-free traffic.
        do_reset();
        chk("reset dat",  dout,       40'd0);
        chk("reset lock", 40'(lock),  40'd0);
        chk("reset off",  40'(off),   40'd0);
        last = '0;
        for (int i = 0; i < 1000; i++) begin
            w = dbl(20'($urandom));
            step(1'b1, w);
            chk("idle lock", 40'(lock), 40'd0);
            chk("idle off",  40'(off),  40'd0);
            chk("idle dat",  dout,      last);
            last = w;
        end

        // Stream shifted by 3 bits: acquire, lock, realign.
        do_reset();
        for (int n = 0; n < 12; n++) begin
            step(vt[n].en, vt[n].dat);
            chk("tbl lock", 40'(lock), 40'(vt[n].exp_lock));
            chk("tbl off",  40'(off),  40'(vt[n].exp_off));
            if (vt[n].chk_dat) chk("tbl dat", dout, vt[n].exp_dat);
        end

        // Wrong-offset tokens at 7: unlock after the 4th, relock at 7.
        for (int j = 0; j < 13; j++) begin
            step_chk(1'b1, tok(7), (j < 4) || (j == 12), (j < 5) ? 4'd3 : 4'd7, "wrong7");
        end

        // Locked at 7: a correct hit after three wrong ones clears the error count.
        seq_c2 = '{tok(3), tok(3), tok(3), tok(7), tok(3), tok(3), tok(3), tok(3), tok(3)};
        for (int j = 0; j < 9; j++) begin
            step_chk(1'b1, seq_c2[j], (j < 8), 4'd7, "errclr");
        end

        // VERIFY timeout at exactly the limit.
        do_reset();
        step(1'b1, tok(5));
        step(1'b1, tok(5));
        chk("tmo verify off", 40'(off), 40'd5);
        repeat (4096) step(1'b1, '0);
        chk("tmo lock", 40'(lock), 40'd0);
        chk("tmo off",  40'(off),  40'd5);
        step_chk(1'b1, tok(2), 1'b0, 4'd5, "tmo edge");
        step_chk(1'b1, '0,     1'b0, 4'd2, "tmo research");

        // One cycle short of the timeout: still VERIFY, another offset only drops to SEARCH.
        do_reset();
        step(1'b1, tok(5));
        step(1'b1, tok(5));
        repeat (4095) step(1'b1, '0);
        step_chk(1'b1, tok(2), 1'b0, 4'd5, "pretmo wait");
        step_chk(1'b1, tok(2), 1'b0, 4'd5, "pretmo other");
        step_chk(1'b1, '0,     1'b0, 4'd2, "pretmo search");

        // Enable drop, resume, then asynchronous reset while locked.
        do_reset();
        lock_at(4);
        step_chk(1'b0, tok(4), 1'b0, 4'd4, "en low");
        step_chk(1'b1, tok(4), 1'b0, 4'd4, "en resume");
        lock_at(4);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("async dat",  dout,      40'd0);
        chk("async lock", 40'(lock), 40'd0);
        chk("async off",  40'(off),  40'd0);
        @(negedge clk);
        en   = 1'b0;
        din  = '0;
        rstn = 1'b1;

`ifdef VID_PHY_CONTROLLER_V2_2_20_ALIGN_STAT_EN
        do_reset();
        chk("stat reset", 40'(relock), 40'd0);
        for (int u = 0; u < 3; u++) begin
            lock_at(3);
            step(1'b0, tok(3));
            chk("stat count", 40'(relock), 40'(u + 1));
        end
        lock_at(3);
        @(negedge clk);
        en       = 1'b0;
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("stat clr lock", 40'(lock),   40'd0);
        chk("stat clr cnt",  40'(relock), 40'd0);
        @(negedge clk);
        stat_clr = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
